simple_processor: RTL and testbench

//  Minimal multi-cycle 16-bit processor: eight 16-bit GPRs (r0..r7), an adder/subtractor and a control FSM.
//  One instruction word arrives on DIN per run request; done pulses when that instruction completes.
//  Top-level leaf for FPGA bring-up; no memory interface, and results are observed via internal registers.

---
 rtl/simple_processor_if.sv | 10 +
 rtl/simple_processor.sv | 179 +++++++++++++++++
 tb/tb_simple_processor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/simple_processor_if.sv
// Bundles the run/DIN/done signals between an instruction source and simple_processor.
// The core keeps its discrete ports; this bundle is for the instruction source side.
interface simple_processor_if;
  logic        run;
  logic [15:0] DIN;
  logic        done;

  modport master (output run, output DIN, input done);
  modport slave  (input run, input DIN, output done);
endinterface

// File: rtl/simple_processor.sv
// Multi-cycle 16-bit processor: eight GPRs, add/sub datapath and a T0..T3 control FSM.
// One instruction is fetched per run request in T0; done pulses for one cycle on retire.
module simple_processor (
  input  logic        clk_50MHz,
  input  logic        reset_n,
  input  logic        run,
  input  logic [15:0] DIN,
  output logic        done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t      state_q;
  logic [15:0] ir_q;
  logic [15:0] a_q;
  logic [15:0] g_q;
  logic        done_q;

  // Register file kept as discrete names so it can be probed hierarchically.
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

  logic [2:0]  op;
  logic        imm;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [15:0] simm;
  logic [15:0] rx_val;
  logic [15:0] ry_val;
  logic [15:0] operand;
  logic [15:0] alu_d;
  logic        is_arith;
  logic        wr_en;
  logic [15:0] wr_data;

  always_comb begin
    op       = ir_q[15:13];
    imm      = ir_q[12];
    rx       = ir_q[11:9];
    ry       = ir_q[2:0];
    simm     = {{7{ir_q[8]}}, ir_q[8:0]};
    is_arith = (op == OP_ADD) || (op == OP_SUB);
  end

  always_comb begin
    rx_val = '0;
    case (rx)
      3'd0: rx_val = r0;
      3'd1: rx_val = r1;
      3'd2: rx_val = r2;
      3'd3: rx_val = r3;
      3'd4: rx_val = r4;
      3'd5: rx_val = r5;
      3'd6: rx_val = r6;
      3'd7: rx_val = r7;
      default: rx_val = '0;
    endcase
  end

  always_comb begin
    ry_val = '0;
    case (ry)
      3'd0: ry_val = r0;
      3'd1: ry_val = r1;
      3'd2: ry_val = r2;
      3'd3: ry_val = r3;
      3'd4: ry_val = r4;
      3'd5: ry_val = r5;
      3'd6: ry_val = r6;
      3'd7: ry_val = r7;
      default: ry_val = '0;
    endcase
  end

  // Operand is read live in T2, so rX==rY sees the value from before the T3 write.
  always_comb begin
    operand = imm ? simm : ry_val;
    alu_d   = (op == OP_SUB) ? (a_q - operand) : (a_q + operand);
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    case (state_q)
      T1: begin
        if (op == OP_MV) begin
          wr_en   = 1'b1;
          wr_data = operand;
        end else if (op == OP_MVT) begin
          wr_en   = 1'b1;
          wr_data = {ir_q[7:0], 8'h00};
        end
      end
      T3: begin
        wr_en   = 1'b1;
        wr_data = g_q;
      end
      default: begin
        wr_en   = 1'b0;
        wr_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        T0: begin
          if (run) begin
            ir_q    <= DIN;
            state_q <= T1;
          end
        end
        T1: begin
          if (is_arith) begin
            a_q     <= rx_val;
            state_q <= T2;
          end else begin
            done_q  <= 1'b1;
            state_q <= T0;
          end
        end
        T2: begin
          g_q     <= alu_d;
          state_q <= T3;
        end
        T3: begin
          done_q  <= 1'b1;
          state_q <= T0;
        end
        default: state_q <= T0;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      r4 <= '0;
      r5 <= '0;
      r6 <= '0;
      r7 <= '0;
    end else if (wr_en) begin
      case (rx)
        3'd0: r0 <= wr_data;
        3'd1: r1 <= wr_data;
        3'd2: r2 <= wr_data;
        3'd3: r3 <= wr_data;
        3'd4: r4 <= wr_data;
        3'd5: r5 <= wr_data;
        3'd6: r6 <= wr_data;
        3'd7: r7 <= wr_data;
        default: ;
      endcase
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_simple_processor.sv
// Directed-vector bench for simple_processor with hand-computed register and latency expectations.
module tb_simple_processor;

  logic clk_50MHz;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  simple_processor_if bus ();

  simple_processor uut (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .run       (bus.run),
    .DIN       (bus.DIN),
    .done      (bus.done)
  );

  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd_reg(input int unsigned idx);
    case (idx)
      0: return uut.r0;
      1: return uut.r1;
      2: return uut.r2;
      3: return uut.r3;
      4: return uut.r4;
      5: return uut.r5;
      6: return uut.r6;
      default: return uut.r7;
    endcase
  endfunction

  task automatic check_regs(input string tag, input logic [15:0] exp [8]);
    for (int unsigned i = 0; i < 8; i++)
      check_eq($sformatf("%s_r%0d", tag, i), rd_reg(i), exp[i]);
  endtask

  // Presents one instruction while the core is in T0; returns just after the retiring edge.
  task automatic step(input string tag, input logic [15:0] din, input int lat, input bit hold);
    int n;
    bus.DIN = din;
    bus.run = 1'b1;
    @(posedge clk_50MHz); #1;
    bus.DIN = 16'hA5A5;
    bus.run = hold;
    check_eq({tag, "_done_low"}, 16'(bus.done), 16'h0000);
    n = 0;
    do begin
      @(posedge clk_50MHz); #1;
      n++;
    end while (!bus.done && n < 8);
    check_eq({tag, "_latency"}, 16'(n), 16'(lat));
  endtask

  logic [15:0] exp_regs [8];

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    bus.run = 1'b1;
    bus.DIN = 16'h101C;

    // Reset held with run=1: nothing moves.
    repeat (3) @(posedge clk_50MHz);
    #1;
    check_eq("rst_done", 16'(bus.done), 16'h0000);
    check_eq("rst_state", 16'(uut.state_q), 16'h0000);
    exp_regs = '{default: 16'h0000};
    check_regs("rst", exp_regs);

    @(negedge clk_50MHz);
    reset_n = 1'b1;
    step("mv_r0_28", 16'h101C, 1, 1'b0);
    check_eq("mv_r0_28_val", uut.r0, 16'h001C);
    @(posedge clk_50MHz); #1;
    check_eq("done_one_cycle", 16'(bus.done), 16'h0000);

    step("mv_r1_r0", 16'h0200, 1, 1'b0);
    check_eq("mv_r1_r0_val", uut.r1, 16'h001C);

    step("mvt_r1", 16'h32FF, 1, 1'b0);
    check_eq("mvt_r1_val", uut.r1, 16'hFF00);
    step("add_r1_imm", 16'h52FF, 3, 1'b0);
    check_eq("add_r1_imm_val", uut.r1, 16'hFFFF);

    step("mv_r0_m1", 16'h11FF, 1, 1'b0);
    check_eq("mv_r0_m1_val", uut.r0, 16'hFFFF);
    step("add_wrap", 16'h5001, 3, 1'b0);
    check_eq("add_wrap_val", uut.r0, 16'h0000);
    step("sub_wrap", 16'h7001, 3, 1'b0);
    check_eq("sub_wrap_val", uut.r0, 16'hFFFF);

    // Back-to-back with run held high; add r3,r3 doubles r3.
    step("b2b_mv_r2", 16'h1405, 1, 1'b1);
    step("b2b_add_r2", 16'h5403, 3, 1'b1);
    step("b2b_mv_r3", 16'h0602, 1, 1'b1);
    step("b2b_add_r3r3", 16'h4603, 3, 1'b0);
    check_eq("b2b_r2", uut.r2, 16'h0008);
    check_eq("b2b_r3", uut.r3, 16'h0010);

    step("nop", 16'h8000, 1, 1'b0);
    exp_regs = '{16'hFFFF, 16'hFFFF, 16'h0008, 16'h0010,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    check_regs("nop", exp_regs);

    // Reset during T2 of add r3,#1.
    bus.DIN = 16'h5601;
    bus.run = 1'b1;
    @(posedge clk_50MHz); #1;
    bus.run = 1'b0;
    @(posedge clk_50MHz); #1;
    check_eq("abort_in_t2", 16'(uut.state_q), 16'h0002);
    reset_n = 1'b0;
    #1;
    check_eq("abort_state", 16'(uut.state_q), 16'h0000);
    check_eq("abort_a", uut.a_q, 16'h0000);
    check_eq("abort_ir", uut.ir_q, 16'h0000);
    exp_regs = '{default: 16'h0000};
    check_regs("abort", exp_regs);
    @(negedge clk_50MHz);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_50MHz); #1;
      check_eq($sformatf("abort_no_done%0d", i), 16'(bus.done), 16'h0000);
    end
    check_eq("abort_r3", uut.r3, 16'h0000);
    check_eq("abort_g", uut.g_q, 16'h0000);

    step("post_mv_r2", 16'h1405, 1, 1'b0);
    check_eq("post_mv_r2_val", uut.r2, 16'h0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
